// File: rtl/layer_weight_scheduler_pkg.sv
// Shared definitions for the layer weight scheduler.
//  - FSM state encoding
//  - datapath geometry: 4 neural units x 4 inputs = 16 weights per layer
package layer_weight_scheduler_pkg;

    localparam int NUM_UNITS         = 4;
    localparam int INPUTS_PER_UNIT   = 4;
    localparam int WEIGHTS_PER_LAYER = NUM_UNITS * INPUTS_PER_UNIT;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DRAIN     = 3'd2,
        ST_SUM       = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_LATCH     = 3'd5,
        ST_FINISH    = 3'd6
    } state_t;

endpackage

// File: rtl/layer_weight_scheduler_if.sv
// Bundle between the scheduler and its surroundings (ROM loader handshake,
// weight RAM port, neural unit strobes, data register bank control).
//  master : the scheduler (drives RAM address, unit strobes, status)
//  slave  : the environment (drives start, units_done, RAM read data)
interface layer_weight_scheduler_if #(
    parameter int ADDR_W = 7
);
    import layer_weight_scheduler_pkg::*;

    logic                               start;
    logic [NUM_UNITS-1:0]               units_done;
    logic [7:0]                         ram_data;
    logic [ADDR_W-1:0]                  ram_address;
    logic [7:0]                         weight;
    logic [NUM_UNITS-1:0]               unit_write;
    logic [$clog2(INPUTS_PER_UNIT)-1:0] unit_address;
    logic                               sum_trigger;
    logic [1:0]                         layer;
    logic                               layer_sel;
    logic                               latch_outputs;
    logic                               busy;
    logic                               done;
    logic                               error;

    modport master (
        input  start, units_done, ram_data,
        output ram_address, weight, unit_write, unit_address, sum_trigger,
               layer, layer_sel, latch_outputs, busy, done, error
    );

    modport slave (
        output start, units_done, ram_data,
        input  ram_address, weight, unit_write, unit_address, sum_trigger,
               layer, layer_sel, latch_outputs, busy, done, error
    );

endinterface

// File: rtl/layer_weight_scheduler_wait_timer.sv
// Loadable 8-bit down-counter used to bound the wait for the neural units.
//  clk, reset  : clock, synchronous active-high reset
//  load        : load load_value (takes priority over counting)
//  load_value  : value to count down from
//  count_en    : decrement by one per cycle, saturating at zero
//  expired     : count has reached zero
module layer_weight_scheduler_wait_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       count_en,
    output logic       expired
);

    logic [7:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= 8'd0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (count_en && (count_reg != 8'd0)) begin
            count_reg <= count_reg - 8'd1;
        end
    end

    assign expired = (count_reg == 8'd0);

endmodule

// File: rtl/layer_weight_scheduler.sv
// Sequences one inference over NUM_LAYERS layers of the 4-unit datapath:
// stream 16 weights from the weight RAM into the units, fire sum_trigger,
// wait for all units, latch their outputs and move to the next layer.
//  clk, reset : clock, synchronous active-high reset
//  bus        : master side of layer_weight_scheduler_if
//               in : start, units_done, ram_data
//               out: ram_address, weight, unit_write, unit_address,
//                    sum_trigger, layer, layer_sel, latch_outputs,
//                    busy, done, error
module layer_weight_scheduler #(
    parameter int NUM_LAYERS = 4,
    parameter int ADDR_W     = 7,
    parameter int BASE_ADDR  = 0,
    parameter int TIMEOUT    = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    layer_weight_scheduler_if.master bus
);
    import layer_weight_scheduler_pkg::*;

    if (NUM_LAYERS < 1 || NUM_LAYERS > 4) begin : g_chk_layers
        $error("layer_weight_scheduler: NUM_LAYERS must be 1..4");
    end
    if (BASE_ADDR + WEIGHTS_PER_LAYER * NUM_LAYERS > (1 << ADDR_W)) begin : g_chk_addr
        $error("layer_weight_scheduler: weight table does not fit in the RAM address space");
    end
    if (TIMEOUT < 1 || TIMEOUT > 256) begin : g_chk_timeout
        $error("layer_weight_scheduler: TIMEOUT must be 1..256");
    end

    localparam logic [1:0] LAST_LAYER = 2'(NUM_LAYERS - 1);
    localparam logic [3:0] K_LAST     = 4'(WEIGHTS_PER_LAYER - 1);
    // Expiry is flagged on the TIMEOUT-th cycle spent in WAIT_DONE.
    localparam logic [7:0] TIMER_LOAD = 8'(TIMEOUT - 1);

    state_t               state_reg;
    logic [3:0]           k_reg;
    logic [1:0]           layer_reg;
    logic                 layer_sel_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic                 error_reg;
    logic                 sum_trigger_reg;
    logic                 latch_outputs_reg;

    // Read-return pipeline: RAM data arrives one cycle after its address.
    logic                 fetch_d_reg;
    logic [3:0]           k_d_reg;
    logic [7:0]           weight_reg;
    logic [NUM_UNITS-1:0] unit_write_reg;
    logic [1:0]           unit_address_reg;
    logic [NUM_UNITS-1:0] strobe_next;

    logic                 timer_expired;

    layer_weight_scheduler_wait_timer u_wait_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (state_reg == ST_SUM),
        .load_value (TIMER_LOAD),
        .count_en   (state_reg == ST_WAIT_DONE),
        .expired    (timer_expired)
    );

    // {layer, k} is layer*16 + unit*4 + input; wraps modulo 2^ADDR_W.
    assign bus.ram_address = ADDR_W'(BASE_ADDR) + ADDR_W'({layer_reg, k_reg});

    genvar gi;
    for (gi = 0; gi < NUM_UNITS; gi++) begin : g_strobe
        assign strobe_next[gi] = fetch_d_reg && (k_d_reg[3:2] == 2'(gi));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_d_reg      <= 1'b0;
            k_d_reg          <= 4'd0;
            weight_reg       <= 8'd0;
            unit_write_reg   <= '0;
            unit_address_reg <= 2'd0;
        end else begin
            fetch_d_reg    <= (state_reg == ST_FETCH);
            k_d_reg        <= k_reg;
            unit_write_reg <= strobe_next;
            if (fetch_d_reg) begin
                weight_reg       <= bus.ram_data;
                unit_address_reg <= k_d_reg[1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= ST_IDLE;
            k_reg             <= 4'd0;
            layer_reg         <= 2'd0;
            layer_sel_reg     <= 1'b0;
            busy_reg          <= 1'b0;
            done_reg          <= 1'b0;
            error_reg         <= 1'b0;
            sum_trigger_reg   <= 1'b0;
            latch_outputs_reg <= 1'b0;
        end else begin
            sum_trigger_reg   <= 1'b0;
            latch_outputs_reg <= 1'b0;
            done_reg          <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_reg     <= ST_FETCH;
                        busy_reg      <= 1'b1;
                        layer_reg     <= 2'd0;
                        layer_sel_reg <= 1'b0;
                        error_reg     <= 1'b0;
                        k_reg         <= 4'd0;
                    end
                end
                ST_FETCH: begin
                    k_reg <= k_reg + 4'd1;
                    if (k_reg == K_LAST) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    state_reg <= ST_SUM;
                end
                ST_SUM: begin
                    sum_trigger_reg <= 1'b1;
                    state_reg       <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    // All-done is tested first so it wins over a coincident timeout.
                    if (bus.units_done == {NUM_UNITS{1'b1}}) begin
                        state_reg <= ST_LATCH;
                    end else if (timer_expired) begin
                        error_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                ST_LATCH: begin
                    latch_outputs_reg <= 1'b1;
                    if (layer_reg != LAST_LAYER) begin
                        layer_reg     <= layer_reg + 2'd1;
                        layer_sel_reg <= 1'b1;
                        k_reg         <= 4'd0;
                        state_reg     <= ST_FETCH;
                    end else begin
                        state_reg <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.weight        = weight_reg;
    assign bus.unit_write    = unit_write_reg;
    assign bus.unit_address  = unit_address_reg;
    assign bus.sum_trigger   = sum_trigger_reg;
    assign bus.layer         = layer_reg;
    assign bus.layer_sel     = layer_sel_reg;
    assign bus.latch_outputs = latch_outputs_reg;
    assign bus.busy          = busy_reg;
    assign bus.done          = done_reg;
    assign bus.error         = error_reg;

endmodule

// File: tb/tb_layer_weight_scheduler.sv
// Directed bench for layer_weight_scheduler: a one-layer and a four-layer
// instance share clock, reset and a weight RAM image (mem[i] = i).
// Expected weight strobes are queued when a run is started and popped as
// the scheduler emits them.
module tb_layer_weight_scheduler;

    localparam int TMO = 30;

    typedef struct packed {
        logic [1:0] layer;
        logic       layer_sel;
        logic [3:0] uw;
        logic [1:0] ua;
        logic [7:0] w;
    } strobe_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    layer_weight_scheduler_if #(.ADDR_W(7)) bus1 ();
    layer_weight_scheduler_if #(.ADDR_W(7)) bus4 ();

    layer_weight_scheduler #(.NUM_LAYERS(1), .ADDR_W(7), .BASE_ADDR(0), .TIMEOUT(TMO)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    layer_weight_scheduler #(.NUM_LAYERS(4), .ADDR_W(7), .BASE_ADDR(0), .TIMEOUT(TMO)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    // Weight RAM model: single port, one-cycle registered read.
    logic [7:0] mem [0:127];
    always @(posedge clk) begin
        bus1.ram_data <= mem[bus1.ram_address];
        bus4.ram_data <= mem[bus4.ram_address];
    end

    int checks = 0;
    int errors = 0;
    int sum1 = 0, latch1 = 0, done1 = 0;
    int sum4 = 0, latch4 = 0, done4 = 0;
    strobe_t q1[$];
    strobe_t q4[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic strobe_t exp_strobe(input int lay, input int n);
        strobe_t s;
        s.layer     = 2'(lay);
        s.layer_sel = (lay != 0);
        s.uw        = 4'(1 << (n / 4));
        s.ua        = 2'(n % 4);
        s.w         = mem[lay * 16 + n];
        return s;
    endfunction

    task automatic push1();
        for (int n = 0; n < 16; n++) q1.push_back(exp_strobe(0, n));
    endtask

    task automatic push4(input int nl);
        for (int l = 0; l < nl; l++)
            for (int n = 0; n < 16; n++) q4.push_back(exp_strobe(l, n));
    endtask

    // Advance to the next falling edge, then count pulses and score strobes.
    task automatic tick();
        @(negedge clk);
        if (bus1.sum_trigger)   sum1++;
        if (bus1.latch_outputs) latch1++;
        if (bus1.done)          done1++;
        if (bus4.sum_trigger)   sum4++;
        if (bus4.latch_outputs) latch4++;
        if (bus4.done)          done4++;
        if (bus1.unit_write != 4'd0) begin
            chk("strobe1_queued", 64'(q1.size() != 0), 64'd1);
            if (q1.size() != 0)
                chk("strobe1", 64'({bus1.layer, bus1.layer_sel, bus1.unit_write, bus1.unit_address, bus1.weight}),
                    64'(q1.pop_front()));
        end
        if (bus4.unit_write != 4'd0) begin
            chk("strobe4_queued", 64'(q4.size() != 0), 64'd1);
            if (q4.size() != 0)
                chk("strobe4", 64'({bus4.layer, bus4.layer_sel, bus4.unit_write, bus4.unit_address, bus4.weight}),
                    64'(q4.pop_front()));
        end
        $display("t=%0t l1: busy=%0b uw=%b w=%0d done=%0b err=%0b | l4: busy=%0b layer=%0d addr=%0d uw=%b w=%0d done=%0b",
                 $time, bus1.busy, bus1.unit_write, bus1.weight, bus1.done, bus1.error,
                 bus4.busy, bus4.layer, bus4.ram_address, bus4.unit_write, bus4.weight, bus4.done);
    endtask

    task automatic cyc(input int n);
        repeat (n) tick();
    endtask

    // Start is sampled on the rising edge in between; returns one cycle later.
    task automatic pulse1();
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
    endtask

    task automatic pulse4();
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
    endtask

    initial begin
        int n, s_d, l_d, d_d;
        for (int i = 0; i < 128; i++) mem[i] = 8'(i);
        reset = 1'b1;
        bus1.start = 1'b0; bus1.units_done = 4'd0;
        bus4.start = 1'b0; bus4.units_done = 4'd0;
        cyc(3);

        // Reset state
        chk("reset_outs1", 64'({bus1.weight, bus1.unit_write, bus1.unit_address, bus1.sum_trigger, bus1.layer,
                                bus1.layer_sel, bus1.latch_outputs, bus1.busy, bus1.done, bus1.error}), 64'd0);
        chk("reset_addr1", 64'(bus1.ram_address), 64'd0);
        chk("reset_outs4", 64'({bus4.weight, bus4.unit_write, bus4.unit_address, bus4.sum_trigger, bus4.layer,
                                bus4.layer_sel, bus4.latch_outputs, bus4.busy, bus4.done, bus4.error}), 64'd0);
        chk("reset_addr4", 64'(bus4.ram_address), 64'd0);
        reset = 1'b0;
        cyc(2);

        // One layer, units immediately done: 16 strobes, done 21 cycles after start
        bus1.units_done = 4'hF;
        push1();
        s_d = sum1; l_d = latch1; d_d = done1;
        pulse1();
        chk("l1_busy_after_start", 64'(bus1.busy), 64'd1);
        n = 0;
        while (!bus1.done && n < 60) begin tick(); n++; end
        chk("l1_start_to_done", 64'(n), 64'd21);
        chk("l1_busy_at_done", 64'(bus1.busy), 64'd0);
        cyc(2);
        chk("l1_sum_pulses", 64'(sum1 - s_d), 64'd1);
        chk("l1_latch_pulses", 64'(latch1 - l_d), 64'd1);
        chk("l1_done_pulses", 64'(done1 - d_d), 64'd1);
        chk("l1_strobes_left", 64'(q1.size()), 64'd0);

        // Start during FETCH and during FINISH is ignored
        push1();
        d_d = done1;
        pulse1();
        cyc(5);
        pulse1();
        cyc(14);
        pulse1();
        chk("ign_done_pulse", 64'(bus1.done), 64'd1);
        chk("ign_busy_at_done", 64'(bus1.busy), 64'd0);
        cyc(2);
        chk("ign_finish_start", 64'(bus1.busy), 64'd0);
        chk("ign_done_count", 64'(done1 - d_d), 64'd1);
        chk("ign_strobes_left", 64'(q1.size()), 64'd0);

        // Units stuck at 0111: error on the TIMEOUT-th WAIT_DONE cycle
        bus1.units_done = 4'b0111;
        push1();
        d_d = done1;
        pulse1();
        cyc(47);
        chk("tmo_err_early", 64'(bus1.error), 64'd0);
        chk("tmo_busy_early", 64'(bus1.busy), 64'd1);
        tick();
        chk("tmo_err", 64'(bus1.error), 64'd1);
        chk("tmo_busy", 64'(bus1.busy), 64'd0);
        cyc(3);
        chk("tmo_no_done", 64'(done1 - d_d), 64'd0);
        chk("tmo_err_sticky", 64'(bus1.error), 64'd1);

        // Next start clears the error and reruns normally
        bus1.units_done = 4'hF;
        push1();
        d_d = done1;
        pulse1();
        chk("rerun_err_clr", 64'(bus1.error), 64'd0);
        n = 0;
        while (!bus1.done && n < 60) begin tick(); n++; end
        chk("rerun_start_to_done", 64'(n), 64'd21);
        chk("rerun_done_count", 64'(done1 - d_d), 64'd1);

        // All-done arriving on the timeout cycle wins
        bus1.units_done = 4'b0111;
        push1();
        l_d = latch1; d_d = done1;
        pulse1();
        cyc(47);
        bus1.units_done = 4'hF;
        tick();
        chk("tie_no_err", 64'(bus1.error), 64'd0);
        cyc(2);
        chk("tie_done", 64'(bus1.done), 64'd1);
        chk("tie_err_after", 64'(bus1.error), 64'd0);
        chk("tie_latch", 64'(latch1 - l_d), 64'd1);
        chk("tie_done_count", 64'(done1 - d_d), 64'd1);

        // Four layers, layer 0 sees units_done rise one bit at a time
        bus4.units_done = 4'd0;
        push4(4);
        s_d = sum4; l_d = latch4; d_d = done4;
        pulse4();
        n = 0;
        while (!bus4.sum_trigger && n < 40) begin tick(); n++; end
        chk("l4_first_sum", 64'(n), 64'd18);
        bus4.units_done = 4'b0001; cyc(5);
        bus4.units_done = 4'b0011; cyc(5);
        bus4.units_done = 4'b0111; cyc(5);
        chk("ramp_no_latch", 64'(latch4 - l_d), 64'd0);
        chk("ramp_busy", 64'(bus4.busy), 64'd1);
        bus4.units_done = 4'hF;
        tick();
        chk("ramp_latch_wait", 64'(bus4.latch_outputs), 64'd0);
        tick();
        chk("ramp_latch", 64'(bus4.latch_outputs), 64'd1);
        chk("ramp_layer1", 64'({bus4.layer, bus4.layer_sel}), 64'({2'd1, 1'b1}));
        n = 0;
        while (!bus4.done && n < 200) begin tick(); n++; end
        chk("l4_done_seen", 64'(bus4.done), 64'd1);
        chk("l4_final_layer", 64'(bus4.layer), 64'd3);
        chk("l4_latch_pulses", 64'(latch4 - l_d), 64'd4);
        chk("l4_sum_pulses", 64'(sum4 - s_d), 64'd4);
        chk("l4_done_pulses", 64'(done4 - d_d), 64'd1);
        chk("l4_strobes_left", 64'(q4.size()), 64'd0);
        cyc(2);

        // Reset in the middle of layer 1 fetch (k = 7)
        push4(2);
        pulse4();
        cyc(27);
        chk("mid_layer", 64'(bus4.layer), 64'd1);
        chk("mid_addr", 64'(bus4.ram_address), 64'd23);
        chk("mid_busy", 64'(bus4.busy), 64'd1);
        reset = 1'b1;
        l_d = latch4; d_d = done4;
        tick();
        chk("mid_reset_outs4", 64'({bus4.weight, bus4.unit_write, bus4.unit_address, bus4.sum_trigger, bus4.layer,
                                    bus4.layer_sel, bus4.latch_outputs, bus4.busy, bus4.done, bus4.error}), 64'd0);
        chk("mid_reset_addr4", 64'(bus4.ram_address), 64'd0);
        reset = 1'b0;
        q4.delete();
        cyc(6);
        chk("mid_no_latch", 64'(latch4 - l_d), 64'd0);
        chk("mid_no_done", 64'(done4 - d_d), 64'd0);
        chk("mid_idle", 64'({bus4.busy, bus4.unit_write}), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
